// File: rtl/sram_arbiter.sv
// Arbitrates the single-port grid SRAM between the display reader and the
// game-logic reader/writer; display has priority, bounded by a wait counter.
module sram_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_25_2,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_ack,
  output logic [DATA_W-1:0] game_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  typedef enum logic [2:0] {IDLE, DRD1, DRD2, GRD1, GRD2, GWR1, GWR2, GWR3} state_t;

  state_t            state, state_d;
  logic [3:0]        wait_cnt, wait_cnt_d;
  logic [DATA_W-1:0] wdata_r;
  logic              dq_oe;

  logic disp_gnt_d, game_gnt, oe_n_d, we_n_d, dq_oe_d, disp_valid_d, game_ack_d;

  always_ff @(posedge clk_25_2 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (disp_req && !(game_req && wait_cnt == MAX_W)) state_d = DRD1;
        else if (game_req && game_we)                     state_d = GWR1;
        else if (game_req)                                state_d = GRD1;
      end
      DRD1:    state_d = DRD2;
      DRD2:    state_d = IDLE;
      GRD1:    state_d = GRD2;
      GRD2:    state_d = IDLE;
      GWR1:    state_d = GWR2;
      GWR2:    state_d = GWR3;
      GWR3:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes are registered from the next state so they line up with the
  // state they belong to, with no combinational glitches on the SRAM pins.
  always_comb begin
    disp_gnt_d   = (state == IDLE) && (state_d == DRD1);
    game_gnt     = (state == IDLE) && (state_d == GRD1 || state_d == GWR1);
    oe_n_d       = !(state_d inside {DRD1, DRD2, GRD1, GRD2});
    we_n_d       = (state_d != GWR2);
    dq_oe_d      = (state_d inside {GWR1, GWR2, GWR3});
    disp_valid_d = (state == DRD2);
    game_ack_d   = (state == GRD2) || (state == GWR3);
    wait_cnt_d   = wait_cnt;
    if (!game_req || game_gnt)             wait_cnt_d = 4'd0;
    else if (disp_gnt_d && wait_cnt != MAX_W) wait_cnt_d = wait_cnt + 4'd1;
  end

  always_ff @(posedge clk_25_2 or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= 4'd0;
      sram_addr  <= '0;
      wdata_r    <= '0;
      dq_oe      <= 1'b0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      disp_gnt   <= 1'b0;
      disp_valid <= 1'b0;
      game_ack   <= 1'b0;
      disp_rdata <= '0;
      game_rdata <= '0;
    end else begin
      wait_cnt   <= wait_cnt_d;
      dq_oe      <= dq_oe_d;
      sram_we_n  <= we_n_d;
      sram_oe_n  <= oe_n_d;
      disp_gnt   <= disp_gnt_d;
      disp_valid <= disp_valid_d;
      game_ack   <= game_ack_d;
      if (disp_gnt_d) begin
        sram_addr <= disp_addr;
      end else if (game_gnt) begin
        sram_addr <= game_addr;
        wdata_r   <= game_wdata;
      end
      if (state == DRD2) disp_rdata <= sram_dq;
      if (state == GRD2) game_rdata <= sram_dq;
    end
  end

  assign sram_dq = dq_oe ? wdata_r : {DATA_W{1'bz}};

endmodule
